// File: rtl/wallace_pkg.sv
// Shared types and constants for the Wallace multiplier final carry-propagate stage.
//   PROD_W       full product width
//   RES_W        width of the returned product half
//   CHUNK_W_DEF  default adder slice width per cycle
//   cpa_state_t  sequencer states
//   cpa_opnd_t   captured operand payload
//   cpa_nchunk() number of slices for a given slice width
package wallace_pkg;

    localparam int unsigned PROD_W      = 64;
    localparam int unsigned RES_W       = 32;
    localparam int unsigned CHUNK_W_DEF = 16;
    localparam int unsigned TAG_W_DEF   = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } cpa_state_t;

    typedef struct packed {
        logic [PROD_W-1:0] sum;
        logic [PROD_W-1:0] carry;
        logic              hi_sel;
    } cpa_opnd_t;

    // Slice count; chunk_w must divide PROD_W.
    function automatic int unsigned cpa_nchunk(input int unsigned chunk_w);
        return PROD_W / chunk_w;
    endfunction

endpackage

// File: rtl/cpa_chunk.sv
// One W-bit ripple slice of the carry-propagate adder.
//   i_a, i_b   slice operands
//   i_cin      carry in from the previous slice
//   o_sum_c    slice sum (combinational)
//   o_cout_c   carry out of the slice (combinational)
module cpa_chunk #(
    parameter int unsigned W = 16
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_cin,
    output logic [W-1:0] o_sum_c,
    output logic         o_cout_c
);

    assign {o_cout_c, o_sum_c} = {1'b0, i_a} + {1'b0, i_b} + {{W{1'b0}}, i_cin};

endmodule

// File: rtl/wallace_cpa_seq.sv
// Iterative carry-propagate stage: resolves the redundant (sum, carry) pair
// from the last CSA layer into a 64-bit product, one CHUNK_W slice per cycle,
// and hands the selected 32-bit half plus RS tag to the CDB arbiter.
//   clk, rst            clock, synchronous active-high reset
//   flush               abort in-flight operation
//   in_valid/in_ready   operand handshake (sum_vec, carry_vec, hi_sel, in_tag)
//   out_valid/out_ready result handshake (result, product, out_tag)
//   out_cout            carry out of bit 63, only with WALLACE_CPA_COUT_EN
module wallace_cpa_seq
    import wallace_pkg::*;
#(
    parameter int unsigned CHUNK_W = CHUNK_W_DEF,
    parameter int unsigned TAG_W   = TAG_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] sum_vec,
    input  logic [PROD_W-1:0] carry_vec,
    input  logic              hi_sel,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [RES_W-1:0]  result,
    output logic [PROD_W-1:0] product,
    output logic [TAG_W-1:0]  out_tag
`ifdef WALLACE_CPA_COUT_EN
    ,
    output logic              out_cout
`endif
);

    localparam int unsigned      NCHUNK   = cpa_nchunk(CHUNK_W);
    localparam int unsigned      IDX_W    = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

    cpa_state_t         r_state;
    cpa_state_t         w_state_next;
    cpa_opnd_t          r_op;
    logic [IDX_W-1:0]   r_idx;
    logic               r_carry;
    logic [PROD_W-1:0]  r_product;
    logic [PROD_W-1:0]  w_prod_next;
    logic [RES_W-1:0]   r_result;
    logic [TAG_W-1:0]   r_tag;
    logic               r_in_ready;
    logic               r_out_valid;
    logic               r_cout;
    logic [CHUNK_W-1:0] w_a;
    logic [CHUNK_W-1:0] w_b;
    logic [CHUNK_W-1:0] w_s;
    logic               w_c;
    logic               w_capture;
    logic               w_step;
    logic               w_last;

    assign w_capture = (r_state == IDLE) && in_valid && !flush;
    assign w_step    = (r_state == ADD) && !flush;
    assign w_last    = (r_idx == LAST_IDX);

    // Current slice selection; the single adder is reused for every slice.
    assign w_a = r_op.sum[r_idx*CHUNK_W +: CHUNK_W];
    assign w_b = r_op.carry[r_idx*CHUNK_W +: CHUNK_W];

    cpa_chunk #(
        .W (CHUNK_W)
    ) u_chunk (
        .i_a      (w_a),
        .i_b      (w_b),
        .i_cin    (r_carry),
        .o_sum_c  (w_s),
        .o_cout_c (w_c)
    );

    // Product with the current slice written in.
    always_comb begin
        w_prod_next = r_product;
        w_prod_next[r_idx*CHUNK_W +: CHUNK_W] = w_s;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state; flush always returns to IDLE.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE: if (w_capture) w_state_next = ADD;
            ADD: begin
                if (flush)       w_state_next = IDLE;
                else if (w_last) w_state_next = DONE;
            end
            DONE: if (flush || out_ready) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Handshake flags registered from the next state so they are pure state decodes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_in_ready  <= (w_state_next == IDLE);
            r_out_valid <= (w_state_next == DONE);
        end
    end

    // Operand capture and slice-by-slice accumulation.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op      <= '0;
            r_tag     <= '0;
            r_idx     <= '0;
            r_carry   <= 1'b0;
            r_product <= '0;
            r_result  <= '0;
            r_cout    <= 1'b0;
        end else if (w_capture) begin
            r_op      <= '{sum: sum_vec, carry: carry_vec, hi_sel: hi_sel};
            r_tag     <= in_tag;
            r_idx     <= '0;
            r_carry   <= 1'b0;
            r_product <= '0;
            r_result  <= '0;
            r_cout    <= 1'b0;
        end else if (w_step) begin
            r_product <= w_prod_next;
            r_carry   <= w_c;
            r_idx     <= r_idx + IDX_W'(1);
            if (w_last) begin
                r_result <= r_op.hi_sel ? w_prod_next[PROD_W-1:RES_W] : w_prod_next[RES_W-1:0];
                r_cout   <= w_c;
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign product   = r_product;
    assign out_tag   = r_tag;

`ifdef WALLACE_CPA_COUT_EN
    assign out_cout = r_cout;

    // A 32x32 unsigned product always fits in 64 bits.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        (r_state == DONE) |-> (r_cout == 1'b0));
`else
    logic w_unused_cout;
    assign w_unused_cout = r_cout;
`endif

endmodule

// File: tb/tb_wallace_cpa_seq.sv
module tb_wallace_cpa_seq;

    localparam int unsigned TAG_W   = 4;
    localparam int          LATENCY = 4;
    localparam int          II      = 6;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] sum_vec;
    logic [63:0] carry_vec;
    logic        hi_sel;
    logic [3:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic [63:0] product;
    logic [3:0]  out_tag;
`ifdef WALLACE_CPA_COUT_EN
    logic        out_cout;
`endif

    wallace_cpa_seq #(
        .CHUNK_W (16),
        .TAG_W   (TAG_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sum_vec   (sum_vec),
        .carry_vec (carry_vec),
        .hi_sel    (hi_sel),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .product   (product),
        .out_tag   (out_tag)
`ifdef WALLACE_CPA_COUT_EN
        ,
        .out_cout  (out_cout)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] prod;
        logic [31:0] res;
        logic [3:0]  tag;
        int          cap;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    bit   rand_ready = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Reference: the product is simply the modular sum of the two vectors.
    function automatic exp_t model(input logic [63:0] s, input logic [63:0] c,
                                   input logic h, input logic [3:0] t, input int cap);
        exp_t e;
        logic [63:0] p;
        p     = s + c;
        e.prod = p;
        e.res  = h ? p[63:32] : p[31:0];
        e.tag  = t;
        e.cap  = cap;
        return e;
    endfunction

    // Offer one operand; returns (at posedge+1) after the capture edge.
    task automatic issue(input logic [63:0] s, input logic [63:0] c, input logic h,
                         input logic [3:0] t, output int cap);
        int tries;
        tries     = 0;
        cap       = -1;
        in_valid  = 1'b1;
        sum_vec   = s;
        carry_vec = c;
        hi_sel    = h;
        in_tag    = t;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            tries++;
            if (tries > 50) break;
        end
        if (tries > 50) begin
            chk("issue_timeout", 64'(tries), 64'd0);
        end else begin
            cap = cyc + 1;
            q.push_back(model(s, c, h, t, cap));
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int tries);
        tries = 0;
        while (!out_valid && tries < 20) begin
            tick(1);
            tries++;
        end
        if (!out_valid) chk("wait_valid_timeout", 64'(out_valid), 64'd1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q.size() != 0 || out_valid) && n < 300) begin
            tick(1);
            n++;
        end
        chk("drain_queue_empty", 64'(q.size()), 64'd0);
    endtask

    // Random backpressure driver.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) out_ready = 1'($urandom_range(0, 1));
        end
    end

    // Monitor: latency, hold stability, busy in_ready and scoreboard pop on handoff.
    bit          prev_hold = 1'b0;
    logic [63:0] prev_prod;
    logic [31:0] prev_res;
    logic [3:0]  prev_tag;

    always @(negedge clk) begin
        if (rst) begin
            prev_hold = 1'b0;
        end else begin
            if (out_valid) begin
                chk("in_ready_low_in_done", 64'(in_ready), 64'd0);
                if (prev_hold) begin
                    chk("hold_product", product, prev_prod);
                    chk("hold_result", 64'(result), 64'(prev_res));
                    chk("hold_tag", 64'(out_tag), 64'(prev_tag));
                end else if (q.size() == 0) begin
                    chk("unexpected_out_valid", 64'(out_valid), 64'd0);
                end else begin
                    chk("latency", 64'(cyc), 64'(q[0].cap + LATENCY));
                end
                if (out_ready && q.size() != 0) begin
                    exp_t e;
                    e = q.pop_front();
                    chk("product", product, e.prod);
                    chk("result", 64'(result), 64'(e.res));
                    chk("out_tag", 64'(out_tag), 64'(e.tag));
`ifdef WALLACE_CPA_COUT_EN
                    chk("out_cout", 64'(out_cout), 64'd0);
`endif
                end
            end
            prev_hold = out_valid && !out_ready;
            prev_prod = product;
            prev_res  = result;
            prev_tag  = out_tag;
        end
    end

    initial begin
        int cap;
        int last_cap;
        int tries;
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        sum_vec   = '0;
        carry_vec = '0;
        hi_sel    = 1'b0;
        in_tag    = '0;
        out_ready = 1'b1;
        tick(2);

        // Reset values.
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_result", 64'(result), 64'd0);
        chk("rst_product", product, 64'd0);
        chk("rst_out_tag", 64'(out_tag), 64'd0);
        rst = 1'b0;
        tick(1);

        // Cross-slice ripple.
        issue(64'h0000_0000_FFFF_FFFF, 64'h1, 1'b1, 4'd3, cap);
        drain();

        // Maximum product, low half.
        issue(64'hFFFF_FFFE_0000_0000, 64'h1, 1'b0, 4'd5, cap);
        drain();

        // Backpressure: hold 3 cycles, then next operand accepted right after handoff.
        out_ready = 1'b0;
        issue(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4320, 1'b1, 4'd7, cap);
        wait_valid(tries);
        tick(3);
        chk("bp_still_valid", 64'(out_valid), 64'd1);
        out_ready = 1'b1;
        last_cap  = cyc;
        issue(64'h0000_0000_8000_0000, 64'h0000_0000_8000_0000, 1'b1, 4'd9, cap);
        chk("bp_next_capture", 64'(cap), 64'(last_cap + 2));
        drain();

        // Flush in the 2nd ADD cycle.
        issue(64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5556, 1'b0, 4'd11, cap);
        tick(1);
        flush = 1'b1;
        void'(q.pop_back());
        tick(1);
        flush = 1'b0;
        chk("flush_in_ready", 64'(in_ready), 64'd1);
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        tick(6);
        issue(64'd5, 64'd2, 1'b0, 4'd12, cap);
        drain();

        // Flush in DONE with no ready drops the result.
        out_ready = 1'b0;
        issue(64'h77, 64'h88, 1'b0, 4'd13, cap);
        wait_valid(tries);
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        void'(q.pop_back());
        chk("done_flush_drop_valid", 64'(out_valid), 64'd0);
        chk("done_flush_in_ready", 64'(in_ready), 64'd1);
        tick(3);

        // Flush together with out_ready in DONE: delivered exactly once.
        issue(64'h100, 64'h200, 1'b0, 4'd14, cap);
        wait_valid(tries);
        flush     = 1'b1;
        out_ready = 1'b1;
        tick(1);
        flush = 1'b0;
        chk("flush_rdy_out_valid", 64'(out_valid), 64'd0);
        chk("flush_rdy_delivered", 64'(q.size()), 64'd0);
        tick(3);

        // Sync reset in the 3rd ADD cycle.
        issue(64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0002, 1'b1, 4'd6, cap);
        tick(2);
        rst = 1'b1;
        void'(q.pop_back());
        tick(1);
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_result", 64'(result), 64'd0);
        chk("midrst_product", product, 64'd0);
        chk("midrst_out_tag", 64'(out_tag), 64'd0);
        rst = 1'b0;
        tick(1);
        issue(64'h0000_0000_0000_00F0, 64'h0000_0000_0000_000E, 1'b0, 4'd2, cap);
        drain();

        // Back-to-back with out_ready tied high.
        out_ready = 1'b1;
        issue(64'h10, 64'h20, 1'b0, 4'd8, last_cap);
        for (int i = 1; i < 4; i++) begin
            issue(64'(i) << 40, 64'(i) << 8, 1'b1, 4'(8 + i), cap);
            chk("b2b_interval", 64'(cap - last_cap), 64'(II));
            last_cap = cap;
        end
        drain();

        // Randomized products with random backpressure and gaps.
        rand_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            logic [31:0] a;
            logic [31:0] b;
            logic [63:0] p;
            logic [63:0] r;
            a = $urandom;
            b = $urandom;
            p = 64'(a) * 64'(b);
            r = {$urandom, $urandom} & p & ~64'h1;
            issue(p ^ r, r, 1'($urandom_range(0, 1)), 4'(i), cap);
            tick($urandom_range(0, 2));
        end
        rand_ready = 1'b0;
        tick(1);
        out_ready = 1'b1;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
